matrix_op_sequencer: RTL and testbench

//  Parametrised matrix coprocessor core. Fetches operand matrices A and (for binary ops) B from a single-port synchronous RAM.

---
 rtl/coproc_pkg.sv | 34 +++
 rtl/matrix_elem_alu.sv | 65 ++++++
 rtl/matrix_op_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_matrix_op_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_pkg.sv
// Shared definitions for the matrix coprocessor: opcodes, FSM states, element packing.
// No logic of its own.
// Element (r,c) of an N x N matrix lives at bit offset (r*N+c)*ELEM_W.
package coproc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_TRN = 2'b10,
        OP_NEG = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_A   = 3'd1,
        S_WAIT_A = 3'd2,
        S_RD_B   = 3'd3,
        S_WAIT_B = 3'd4,
        S_EXEC   = 3'd5,
        S_WRITE  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    // Bit offset of element (r,c) inside a packed matrix word.
    function automatic int elem_off(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

    // ADD and SUB need a second operand fetched from RAM; TRN and NEG do not.
    function automatic logic op_is_binary(input opcode_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/matrix_elem_alu.sv
// Element-wise matrix ALU: ADD, SUB, TRANSPOSE(A), NEGATE(A) with OR-reduced signed overflow.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module matrix_elem_alu
    import coproc_pkg::*;
#(
    parameter int N      = 5,
    parameter int ELEM_W = 8
) (
    input  logic [N*N*ELEM_W-1:0] i_a,
    input  logic [N*N*ELEM_W-1:0] i_b,
    input  opcode_t               i_op,
    output logic [N*N*ELEM_W-1:0] o_c,
    output logic                  o_ovf
);

    localparam int MSB = ELEM_W - 1;
    localparam logic [ELEM_W-1:0] MOST_NEG = {1'b1, {(ELEM_W-1){1'b0}}};

    logic [ELEM_W-1:0] w_ea;
    logic [ELEM_W-1:0] w_eb;
    logic [ELEM_W-1:0] w_res;

    // Walk every element, compute the wrapped result and flag signed overflow.
    always_comb begin
        o_c   = '0;
        o_ovf = 1'b0;
        w_ea  = '0;
        w_eb  = '0;
        w_res = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                w_ea = i_a[elem_off(r, c, N, ELEM_W) +: ELEM_W];
                w_eb = i_b[elem_off(r, c, N, ELEM_W) +: ELEM_W];
                case (i_op)
                    OP_ADD: begin
                        w_res = w_ea + w_eb;
                        if ((w_ea[MSB] == w_eb[MSB]) && (w_res[MSB] != w_ea[MSB])) begin
                            o_ovf = 1'b1;
                        end
                    end
                    OP_SUB: begin
                        w_res = w_ea - w_eb;
                        if ((w_ea[MSB] != w_eb[MSB]) && (w_res[MSB] != w_ea[MSB])) begin
                            o_ovf = 1'b1;
                        end
                    end
                    OP_TRN: begin
                        // Swap row/column; no arithmetic, so never overflows.
                        w_res = i_a[elem_off(c, r, N, ELEM_W) +: ELEM_W];
                    end
                    default: begin
                        // Negating the most-negative value wraps back to itself.
                        w_res = '0 - w_ea;
                        if (w_ea == MOST_NEG) begin
                            o_ovf = 1'b1;
                        end
                    end
                endcase
                o_c[elem_off(r, c, N, ELEM_W) +: ELEM_W] = w_res;
            end
        end
    end

endmodule

// File: rtl/matrix_op_sequencer.sv
// Matrix coprocessor core: fetch A (and B), run element-wise op, write C back to one RAM port.
// Latency start->done: binary 2*RD_LAT+5 cycles, unary RD_LAT+4 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, not queued.
module matrix_op_sequencer
    import coproc_pkg::*;
#(
    parameter int N      = 5,
    parameter int ELEM_W = 8,
    parameter int MEM_W  = 256,
    parameter int AW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [1:0]       i_opcode,
    input  logic [AW-1:0]    i_addr_a,
    input  logic [AW-1:0]    i_addr_b,
    input  logic [AW-1:0]    i_addr_c,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ovf,
    output logic [AW-1:0]    o_mem_addr,
    output logic             o_mem_wren,
    output logic [MEM_W-1:0] o_mem_wdata,
    input  logic [MEM_W-1:0] i_mem_rdata,
    output logic [7:0]       o_dbg_byte
);

    localparam int PW = N * N * ELEM_W;
    localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    opcode_t          r_op;
    logic [AW-1:0]    r_addr_a;
    logic [AW-1:0]    r_addr_b;
    logic [AW-1:0]    r_addr_c;
    logic [CW-1:0]    r_wait_cnt;
    logic [PW-1:0]    r_a;
    logic [PW-1:0]    r_b;
    logic [PW-1:0]    r_c;
    logic             r_ovf;
    logic [7:0]       r_dbg;

    logic             w_wait_last;
    logic             w_busy;
    logic             w_done;
    logic             w_wren;
    logic [AW-1:0]    w_addr;
    logic [MEM_W-1:0] w_wdata;
    logic [PW-1:0]    w_alu_c;
    logic             w_alu_ovf;
    logic [7:0]       w_dbg;

    assign w_wait_last = (r_wait_cnt == CW'(RD_LAT - 1));

    // Sign-extend (or truncate) element (0,0) of the result for the LED byte.
    assign w_dbg = 8'($signed(r_c[ELEM_W-1:0]));

    matrix_elem_alu #(
        .N      (N),
        .ELEM_W (ELEM_W)
    ) u_alu (
        .i_a   (r_a),
        .i_b   (r_b),
        .i_op  (r_op),
        .o_c   (w_alu_c),
        .o_ovf (w_alu_ovf)
    );

    // RAM bits above the packed matrix carry nothing for us.
    generate
        if (MEM_W > PW) begin : g_rdata_pad
            logic w_unused_rdata;
            assign w_unused_rdata = ^i_mem_rdata[MEM_W-1:PW];
        end
    endgenerate

    // State register; reset drops straight to IDLE, which kills any pending write.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and RAM interface decode; outputs depend on state only so reset clears them at once.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_wren      = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = S_RD_A;
                end
            end
            S_RD_A: begin
                w_addr      = r_addr_a;
                w_state_nxt = S_WAIT_A;
            end
            S_WAIT_A: begin
                w_addr = r_addr_a;
                if (w_wait_last) begin
                    w_state_nxt = op_is_binary(r_op) ? S_RD_B : S_EXEC;
                end
            end
            S_RD_B: begin
                w_addr      = r_addr_b;
                w_state_nxt = S_WAIT_B;
            end
            S_WAIT_B: begin
                w_addr = r_addr_b;
                if (w_wait_last) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_addr      = r_addr_c;
                w_wren      = 1'b1;
                w_wdata     = MEM_W'(r_c);
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request latches, read-latency counter, operand capture and result registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_op       <= OP_ADD;
            r_addr_a   <= '0;
            r_addr_b   <= '0;
            r_addr_c   <= '0;
            r_wait_cnt <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_ovf      <= 1'b0;
            r_dbg      <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_op     <= opcode_t'(i_opcode);
                r_addr_a <= i_addr_a;
                r_addr_b <= i_addr_b;
                r_addr_c <= i_addr_c;
                r_ovf    <= 1'b0;
            end

            if (((r_state == S_WAIT_A) || (r_state == S_WAIT_B)) && !w_wait_last) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end

            if ((r_state == S_WAIT_A) && w_wait_last) begin
                r_a <= i_mem_rdata[PW-1:0];
            end
            if ((r_state == S_WAIT_B) && w_wait_last) begin
                r_b <= i_mem_rdata[PW-1:0];
            end

            if (r_state == S_EXEC) begin
                r_c   <= w_alu_c;
                r_ovf <= w_alu_ovf;
            end

            // Loaded on the way into DONE so the LEDs change together with done.
            if (r_state == S_WRITE) begin
                r_dbg <= w_dbg;
            end
        end
    end

    assign o_busy      = w_busy;
    assign o_done      = w_done;
    assign o_ovf       = r_ovf;
    assign o_mem_addr  = w_addr;
    assign o_mem_wren  = w_wren;
    assign o_mem_wdata = w_wdata;
    assign o_dbg_byte  = r_dbg;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer with a behavioural 1-cycle-latency RAM.
// Expected matrices and latencies are hand-derived constants/helpers.
// Every output comparison goes through chk().
module tb_matrix_op_sequencer;

    localparam logic [1:0] OPC_ADD = 2'b00;
    localparam logic [1:0] OPC_SUB = 2'b01;
    localparam logic [1:0] OPC_TRN = 2'b10;
    localparam logic [1:0] OPC_NEG = 2'b11;
    localparam int LAT_BIN = 7;
    localparam int LAT_UN  = 5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [1:0]   opcode;
    logic [7:0]   addr_a;
    logic [7:0]   addr_b;
    logic [7:0]   addr_c;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [7:0]   mem_addr;
    logic         mem_wren;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic [7:0]   dbg_byte;

    logic [255:0] mem [0:255];
    logic         ld_en;
    logic [7:0]   ld_addr;
    logic [255:0] ld_dat;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    int watch_hits = 0;
    logic [7:0] watch_addr = 8'hFF;

    always #5 clk = ~clk;

    matrix_op_sequencer dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_start     (start),
        .i_opcode    (opcode),
        .i_addr_a    (addr_a),
        .i_addr_b    (addr_b),
        .i_addr_c    (addr_c),
        .o_busy      (busy),
        .o_done      (done),
        .o_ovf       (ovf),
        .o_mem_addr  (mem_addr),
        .o_mem_wren  (mem_wren),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_dbg_byte  (dbg_byte)
    );

    // Behavioural synchronous RAM, one cycle read latency; bench preload port has priority.
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_dat;
        else if (mem_wren) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Event monitors sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_wren) wr_cnt++;
        if (done) done_cnt++;
        if (busy && (mem_addr == watch_addr)) watch_hits++;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [7:0] v);
        logic [255:0] x;
        x = '0;
        for (int i = 0; i < 25; i++) x[i*8 +: 8] = v;
        return x;
    endfunction

    // A(r,c) = r*5+c, or its transpose when trn is set.
    function automatic logic [255:0] idx_mat(input logic trn);
        logic [255:0] x;
        x = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                x[(r*5+c)*8 +: 8] = trn ? 8'(c*5+r) : 8'(r*5+c);
        return x;
    endfunction

    task automatic ram_load(input logic [7:0] a, input logic [255:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_dat = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one op and wait (bounded) for done. repulse>0 re-asserts start with a
    // different request in that cycle after acceptance (cycle 1 = RD_A).
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input int repulse, output int lat,
                          output int writes, output logic [7:0] dbg, output logic ovf_o);
        int w0;
        int cyc;
        @(negedge clk);
        w0 = wr_cnt;
        start = 1'b1; opcode = op; addr_a = a; addr_b = b; addr_c = c;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; lat = 40; dbg = '0; ovf_o = 1'b0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == repulse) begin
                start = 1'b1; opcode = OPC_SUB; addr_a = 8'd4; addr_b = 8'd5; addr_c = 8'd14;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = cyc; dbg = dbg_byte; ovf_o = ovf;
                break;
            end
        end
        @(negedge clk);
        writes = wr_cnt - w0;
    endtask

    initial begin
        int lat;
        int wrs;
        int h0;
        int d0;
        logic [7:0] dbg;
        logic ov;
        logic [255:0] exp;

        reset_n = 1'b0; start = 1'b0; opcode = '0;
        addr_a = '0; addr_b = '0; addr_c = '0;
        ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  256'(busy), 256'(0));
        chk("rst_done",  256'(done), 256'(0));
        chk("rst_ovf",   256'(ovf), 256'(0));
        chk("rst_wren",  256'(mem_wren), 256'(0));
        chk("rst_addr",  256'(mem_addr), 256'(0));
        chk("rst_wdata", mem_wdata, 256'(0));
        chk("rst_dbg",   256'(dbg_byte), 256'(0));
        reset_n = 1'b1;

        // 1. ADD
        ram_load(8'd1, fill(8'h03));
        ram_load(8'd2, fill(8'h04));
        run_op(OPC_ADD, 8'd1, 8'd2, 8'd3, 0, lat, wrs, dbg, ov);
        chk("add_lat", 256'(lat), 256'(LAT_BIN));
        chk("add_mem", mem[3], fill(8'h07));
        chk("add_ovf", 256'(ov), 256'(0));
        chk("add_writes", 256'(wrs), 256'(1));
        chk("add_dbg", 256'(dbg), 256'(8'h07));
        chk("add_idle", 256'(busy), 256'(0));

        // 2a. SUB wrap without overflow
        ram_load(8'd4, fill(8'h00));
        ram_load(8'd5, fill(8'h01));
        run_op(OPC_SUB, 8'd4, 8'd5, 8'd6, 0, lat, wrs, dbg, ov);
        chk("sub_mem", mem[6], fill(8'hFF));
        chk("sub_ovf", 256'(ov), 256'(0));
        chk("sub_dbg", 256'(dbg), 256'(8'hFF));

        // 2b. SUB with signed overflow, ovf held afterwards
        ram_load(8'd7, fill(8'h80));
        run_op(OPC_SUB, 8'd7, 8'd5, 8'd8, 0, lat, wrs, dbg, ov);
        chk("subov_mem", mem[8], fill(8'h7F));
        chk("subov_ovf", 256'(ov), 256'(1));
        repeat (3) @(negedge clk);
        chk("subov_held", 256'(ovf), 256'(1));

        // 3. TRANSPOSE in place; B address must never be driven
        ram_load(8'd10, idx_mat(1'b0));
        watch_addr = 8'd55;
        h0 = watch_hits;
        run_op(OPC_TRN, 8'd10, 8'd55, 8'd10, 0, lat, wrs, dbg, ov);
        chk("trn_lat", 256'(lat), 256'(LAT_UN));
        chk("trn_mem", mem[10], idx_mat(1'b1));
        chk("trn_ovf", 256'(ov), 256'(0));
        chk("trn_no_b", 256'(watch_hits - h0), 256'(0));
        chk("trn_writes", 256'(wrs), 256'(1));
        watch_addr = 8'hFF;

        // 4. NEGATE with most-negative element
        exp = fill(8'h05);
        exp[7:0] = 8'h80;
        ram_load(8'd11, exp);
        run_op(OPC_NEG, 8'd11, 8'd0, 8'd12, 0, lat, wrs, dbg, ov);
        exp = fill(8'hFB);
        exp[7:0] = 8'h80;
        chk("neg_lat", 256'(lat), 256'(LAT_UN));
        chk("neg_mem", mem[12], exp);
        chk("neg_ovf", 256'(ov), 256'(1));
        chk("neg_dbg", 256'(dbg), 256'(8'h80));

        // 5. start re-pulsed in WAIT_B (cycle 4) with a different request
        ram_load(8'd14, fill(8'hAA));
        run_op(OPC_ADD, 8'd1, 8'd2, 8'd13, 4, lat, wrs, dbg, ov);
        chk("prot_lat", 256'(lat), 256'(LAT_BIN));
        chk("prot_mem13", mem[13], fill(8'h07));
        chk("prot_mem14", mem[14], fill(8'hAA));
        chk("prot_writes", 256'(wrs), 256'(1));
        repeat (4) @(negedge clk);
        chk("prot_idle", 256'(busy), 256'(0));

        // 6. reset during WRITE aborts the write; next op runs normally
        ram_load(8'd15, fill(8'hAA));
        @(negedge clk);
        start = 1'b1; opcode = OPC_ADD; addr_a = 8'd1; addr_b = 8'd2; addr_c = 8'd15;
        @(posedge clk);
        #1 start = 1'b0;
        d0 = done_cnt;
        repeat (6) @(negedge clk);
        chk("rstw_wren_pre", 256'(mem_wren), 256'(1));
        reset_n = 1'b0;
        #1;
        chk("rstw_wren", 256'(mem_wren), 256'(0));
        chk("rstw_busy", 256'(busy), 256'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rstw_no_done", 256'(done_cnt - d0), 256'(0));
        chk("rstw_mem", mem[15], fill(8'hAA));
        run_op(OPC_ADD, 8'd1, 8'd2, 8'd15, 0, lat, wrs, dbg, ov);
        chk("rstw_next_lat", 256'(lat), 256'(LAT_BIN));
        chk("rstw_next_mem", mem[15], fill(8'h07));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
